// File: rtl/updown_ctrl_pkg.sv
// Shared types and defaults for the up/down sweep controller.
// Optional dwell-at-turn behaviour is enabled with UPDOWN_CTRL_DWELL_EN.
package updown_ctrl_pkg;

  localparam int unsigned DEF_WIDTH   = 3;
  localparam int unsigned DEF_SWEEP_W = 4;

`ifdef UPDOWN_CTRL_DWELL_EN
  localparam bit DWELL_EN = 1'b1;
`else
  localparam bit DWELL_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    UP       = 3'd1,
    DOWN     = 3'd2
`ifdef UPDOWN_CTRL_DWELL_EN
    ,
    DWELL_HI = 3'd3,
    DWELL_LO = 3'd4
`endif
  } state_e;

endpackage

// File: rtl/updown_cnt.sv
// Loadable up/down counter datapath; load has priority over count enable.
module updown_cnt
  import updown_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en) begin
      count_q <= dir ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/updown_ctrl.sv
// Triangle sweep controller between latched lo/hi bounds with sweep counting.
// Build with UPDOWN_CTRL_DWELL_EN to hold one cycle at each turning point.
module updown_ctrl
  import updown_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned SWEEP_W = DEF_SWEEP_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [WIDTH-1:0]   lo,
  input  logic [WIDTH-1:0]   hi,
  input  logic [SWEEP_W-1:0] sweeps,
  output logic [WIDTH-1:0]   count,
  output logic               updown,
  output logic               busy,
  output logic               done,
  output logic               err
);

  state_e             state_q;
  logic [WIDTH-1:0]   lo_q, hi_q;
  logic [SWEEP_W-1:0] sweeps_q, sweep_q;
  logic               updown_q, busy_q, done_q, err_q;

  logic               cnt_en, cnt_dir, cnt_load;
  logic               at_hi, at_lo, start_ok, bounds_ok, final_sweep;
  logic [SWEEP_W-1:0] sweep_d;

  assign at_hi       = (count >= hi_q);
  assign at_lo       = (count <= lo_q);
  assign start_ok    = start && !stop;
  assign bounds_ok   = (lo < hi);
  // Saturating sweep count keeps continuous runs from ever matching a target.
  assign sweep_d     = (sweep_q == {SWEEP_W{1'b1}}) ? sweep_q : sweep_q + SWEEP_W'(1);
  assign final_sweep = (sweeps_q != '0) && (sweep_d == sweeps_q);

  // Counter control decoded from the current state.
  always_comb begin
    cnt_en   = 1'b0;
    cnt_dir  = 1'b0;
    cnt_load = 1'b0;
    case (state_q)
      IDLE: cnt_load = start_ok && bounds_ok;
      UP: if (!stop) begin
        cnt_en  = !at_hi || !DWELL_EN;
        cnt_dir = !at_hi;
      end
      DOWN: if (!stop) begin
        cnt_en  = !at_lo || (!final_sweep && !DWELL_EN);
        cnt_dir = at_lo;
      end
`ifdef UPDOWN_CTRL_DWELL_EN
      DWELL_HI: cnt_en = !stop;
      DWELL_LO: begin
        cnt_en  = !stop;
        cnt_dir = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      sweeps_q <= '0;
      sweep_q  <= '0;
      updown_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (state_q != IDLE && stop) begin
        state_q  <= IDLE;
        busy_q   <= 1'b0;
        updown_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (start_ok) begin
            if (bounds_ok) begin
              lo_q     <= lo;
              hi_q     <= hi;
              sweeps_q <= sweeps;
              sweep_q  <= '0;
              updown_q <= 1'b1;
              busy_q   <= 1'b1;
              state_q  <= UP;
            end else begin
              err_q <= 1'b1;
            end
          end
          UP: if (at_hi) begin
`ifdef UPDOWN_CTRL_DWELL_EN
            state_q  <= DWELL_HI;
`else
            state_q  <= DOWN;
            updown_q <= 1'b0;
`endif
          end
          DOWN: if (at_lo) begin
            sweep_q <= sweep_d;
            if (final_sweep) begin
              state_q  <= IDLE;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              updown_q <= 1'b0;
            end else begin
`ifdef UPDOWN_CTRL_DWELL_EN
              state_q  <= DWELL_LO;
`else
              state_q  <= UP;
              updown_q <= 1'b1;
`endif
            end
          end
`ifdef UPDOWN_CTRL_DWELL_EN
          DWELL_HI: begin
            state_q  <= DOWN;
            updown_q <= 1'b0;
          end
          DWELL_LO: begin
            state_q  <= UP;
            updown_q <= 1'b1;
          end
`endif
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  updown_cnt #(.WIDTH(WIDTH)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .en       (cnt_en),
    .dir      (cnt_dir),
    .load     (cnt_load),
    .load_val (lo),
    .count    (count)
  );

  assign updown = updown_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_updown_ctrl.sv
// Randomized and directed bench for updown_ctrl against a triangle-wave model.
module tb_updown_ctrl;
  import updown_ctrl_pkg::*;

  localparam int unsigned W  = DEF_WIDTH;
  localparam int unsigned SW = DEF_SWEEP_W;
`ifdef UPDOWN_CTRL_DWELL_EN
  localparam bit DW = 1'b1;
`else
  localparam bit DW = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, start, stop;
  logic [W-1:0]  lo, hi;
  logic [SW-1:0] sweeps;
  logic [W-1:0]  count;
  logic          updown, busy, done, err;

  always #5 clk = ~clk;

  updown_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .lo(lo), .hi(hi),
    .sweeps(sweeps), .count(count), .updown(updown), .busy(busy),
    .done(done), .err(err)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: a run is a triangle wave indexed by cycles since the start edge.
  bit m_act, m_upd, m_busy, m_done, m_err;
  int m_t, m_lo, m_hi, m_sw, m_cnt;

  function automatic int period();
    return DW ? 2 * (m_hi - m_lo) + 2 : 2 * (m_hi - m_lo);
  endfunction

  function automatic int wave_count(int t);
    int d = m_hi - m_lo;
    int m = t % period();
    if (m <= d) return m_lo + m;
    if (DW) return (m == d + 1) ? m_hi : m_hi - (m - d - 1);
    return m_lo + 2 * d - m;
  endfunction

  function automatic bit wave_up(int t);
    int d = m_hi - m_lo;
    int m = t % period();
    if (t == 0) return 1'b1;
    return (m >= 1) && (m <= d);
  endfunction

  task automatic model_reset();
    m_act = 0; m_t = 0; m_lo = 0; m_hi = 0; m_sw = 0;
    m_cnt = 0; m_upd = 0; m_busy = 0; m_done = 0; m_err = 0;
  endtask

  task automatic model_edge();
    int end_t;
    m_done = 0;
    m_err  = 0;
    if (rst) begin
      model_reset();
    end else if (m_act) begin
      if (stop) begin
        m_act = 0; m_busy = 0; m_upd = 0;
      end else begin
        m_t++;
        end_t = DW ? m_sw * period() : m_sw * period() + 1;
        if (m_sw != 0 && m_t == end_t) begin
          m_act = 0; m_busy = 0; m_upd = 0; m_done = 1; m_cnt = m_lo;
        end else begin
          m_cnt = wave_count(m_t);
          m_upd = wave_up(m_t);
        end
      end
    end else if (start && !stop) begin
      if (lo < hi) begin
        m_act = 1; m_t = 0; m_lo = int'(lo); m_hi = int'(hi); m_sw = int'(sweeps);
        m_cnt = m_lo; m_upd = 1; m_busy = 1;
      end else begin
        m_err = 1;
      end
    end
  endtask

  task automatic compare();
    check("count", int'(count), m_cnt);
    check("busy", int'(busy), int'(m_busy));
    check("done", int'(done), int'(m_done));
    check("err", int'(err), int'(m_err));
    if (!DW) check("updown", int'(updown), int'(m_upd));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic start_run(input int l, input int h, input int s);
    lo = W'(l); hi = W'(h); sweeps = SW'(s); start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  int e039[5] = '{2, 3, 2, 1, 1};
`ifdef UPDOWN_CTRL_DWELL_EN
  int e044[12] = '{2, 3, 4, 4, 3, 2, 2, 3, 4, 4, 3, 2};
`endif

  initial begin
    bit hit;
    rst = 1'b1; start = 1'b0; stop = 1'b0; lo = '0; hi = '0; sweeps = '0;
    model_reset();
    #2;
    compare();
    cycle();
    rst = 1'b0;

    // Single sweep 1..3..1; bounds changed mid-run must be ignored.
    start_run(1, 3, 1);
    check("t039_first", int'(count), 1);
    lo = W'(0); hi = W'(7); sweeps = SW'(0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("t039_seq", int'(count), e039[i]);
    end
    check("t039_done", int'(done), 1);
    check("t039_busy", int'(busy), 0);
    cycle();
    check("t039_hold", int'(count), 1);

    // Continuous full-range sweep, long enough to saturate the sweep counter.
    start_run(0, 7, 0);
    repeat (15 * 14 + 20) cycle();
    stop = 1'b1;
    cycle();
    stop = 1'b0;

    // Rejected start then a valid one.
    start_run(5, 5, 1);
    check("t041_err", int'(err), 1);
    cycle();
    check("t041_err_clr", int'(err), 0);
    start_run(2, 5, 2);
    repeat (16) cycle();

    // Stop while counting up at 4; start together with stop is ignored.
    start_run(0, 6, 0);
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (m_cnt == 4 && m_upd) hit = 1;
      else cycle();
    end
    check("t042_reach", int'(hit), 1);
    stop = 1'b1; start = 1'b1;
    cycle();
    check("t042_cnt", int'(count), 4);
    check("t042_busy", int'(busy), 0);
    cycle();
    check("t042_nostart", int'(busy), 0);
    stop = 1'b0; start = 1'b0;
    cycle();

    // Asynchronous reset mid-run, then restart.
    start_run(0, 6, 0);
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (m_cnt == 3) hit = 1;
      else cycle();
    end
    check("t043_reach", int'(hit), 1);
    #2 rst = 1'b1;
    #1;
    check("t043_cnt", int'(count), 0);
    check("t043_busy", int'(busy), 0);
    model_reset();
    cycle();
    rst = 1'b0;
    start_run(1, 4, 1);
    check("t043_restart", int'(busy), 1);
    repeat (10) cycle();

`ifdef UPDOWN_CTRL_DWELL_EN
    // Dwell at every turn except after the final sweep.
    start_run(2, 4, 2);
    check("t044_first", int'(count), e044[0]);
    for (int i = 1; i < 12; i++) begin
      cycle();
      check("t044_seq", int'(count), e044[i]);
    end
    cycle();
    check("t044_done", int'(done), 1);
    cycle();
`endif

    // Random traffic against the model.
    repeat (600) begin
      start = ($urandom_range(0, 3) == 0);
      stop  = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 2) == 0) begin
        lo = W'($urandom);
        hi = W'($urandom);
        sweeps = SW'($urandom_range(0, 3));
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/updown_ctrl.md
UPDOWN_CTRL -- requirements
Module: updown_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 3, setting the width of count, lo and hi.
REQ-002 The block SHALL have parameter SWEEP_W, default 4, setting the width of sweeps and of the internal sweep counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge active.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request to begin a run, sampled on a rising edge.
REQ-006 The block SHALL have port stop, input, 1 bit: synchronous abort.
REQ-007 The block SHALL have port lo, input, WIDTH bits: lower turning bound.
REQ-008 The block SHALL have port hi, input, WIDTH bits: upper turning bound.
REQ-009 The block SHALL have port sweeps, input, SWEEP_W bits: number of sweeps, where 0 means run continuously.
REQ-010 The block SHALL have port count, output, WIDTH bits: the counter value.
REQ-011 The block SHALL have port updown, output, 1 bit: direction, 1 = up, 0 = down.
REQ-012 The block SHALL have port busy, output, 1 bit: a run is in progress.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse marking a completed run.
REQ-014 The block SHALL have port err, output, 1 bit: one-cycle pulse marking a rejected start.

Function
REQ-015 The FSM SHALL have states IDLE, UP, DOWN and, only with the macro, DWELL_HI and DWELL_LO.
REQ-016 In IDLE with start=1 and stop=0, and lo<hi, the block SHALL latch lo/hi/sweeps and, on that same edge, set count=lo, updown=1, busy=1, sweep counter=0, next state UP.
REQ-017 In IDLE with start=1 and lo>=hi, the block SHALL pulse err for one cycle and leave state, count and busy unchanged.
REQ-018 In UP, the block SHALL increment count by 1 per cycle while count<hi_l; when count==hi_l it SHALL decrement by 1, set updown=0 and go to DOWN.
REQ-019 In DOWN, the block SHALL decrement count by 1 per cycle while count>lo_l.
REQ-020 When count==lo_l in DOWN, the block SHALL count one sweep completed (lo->hi->lo).
REQ-021 If sweeps_l!=0 and the completed sweep count equals sweeps_l, the block SHALL hold count at lo_l, pulse done, clear busy and updown, and go to IDLE.
REQ-022 Otherwise, on the same lo_l condition, the block SHALL increment count, set updown=1 and go to UP.
REQ-023 Each sweep SHALL last 2*(hi_l-lo_l) cycles; count SHALL never leave [lo_l,hi_l] and SHALL never wrap modulo 2^WIDTH.
REQ-024 When sweeps=0, the sweep counter SHALL saturate rather than wrap, and done SHALL never assert.
REQ-025 The block SHALL ignore changes on lo/hi/sweeps during a run.
REQ-026 The block SHALL ignore start while busy=1.
REQ-027 When stop=1 in any non-IDLE state, the block SHALL go to IDLE at the next edge: count holds its value, busy=0, updown=0, no done.
REQ-028 When start and stop are both 1 in IDLE, stop SHALL win: no run, no err.
REQ-029 done and err SHALL be registered outputs and SHALL never both be 1 in the same cycle.

Reset
REQ-030 When rst=1, the block SHALL immediately, without waiting for a clock edge, force state=IDLE, count=0, updown=0, busy=0, done=0, err=0, sweep counter=0 and latched bounds=0.
REQ-031 A reset asserted mid-run SHALL abort the run, and no done SHALL follow.
REQ-032 After reset is released, the block SHALL accept start at the first rising edge.

Configuration
REQ-033 When macro UPDOWN_CTRL_DWELL_EN is defined, count SHALL hold for one extra cycle at hi_l (DWELL_HI) and at every intermediate lo_l turn (DWELL_LO) before reversing.
REQ-034 With UPDOWN_CTRL_DWELL_EN defined, there SHALL be no dwell after the final sweep's lo_l, and each non-final sweep SHALL last 2*(hi_l-lo_l)+2 cycles.
REQ-035 When UPDOWN_CTRL_DWELL_EN is undefined, the DWELL states SHALL be absent and reversal SHALL be immediate, as specified under Function.

Structure
REQ-036 Package updown_ctrl_pkg SHALL hold the state enum typedef and the default WIDTH/SWEEP_W constants.
REQ-037 The counter datapath SHALL be a sub-module updown_cnt (ports clk, rst, en, dir, load, load_val, count).
REQ-038 updown_ctrl SHALL hold only the FSM, the latched bounds and the sweep counter, and SHALL drive updown_cnt.

Verification
REQ-039 The bench SHALL check: lo=1, hi=3, sweeps=1, start pulse -> count 1,2,3,2,1 on successive edges; done=1 and busy=0 on the next edge; count stays 1.
REQ-040 The bench SHALL check: lo=0, hi=7, sweeps=0 -> count 0..7..0 repeating; updown flips at 7 and at 0; no wrap; no done after 3 sweeps.
REQ-041 The bench SHALL check: lo=5, hi=5, start -> err=1 for exactly one cycle; busy=0; count unchanged; a later valid start runs normally.
REQ-042 The bench SHALL check: lo=0, hi=6, run to count=4 going up, stop=1 -> next edge IDLE, count=4, busy=0, no done; a start pulsed together with stop is ignored.
REQ-043 The bench SHALL check: rst=1 asserted asynchronously mid-run at count=3 -> count=0, busy=0 before the next edge; restart after release works.
REQ-044 The bench SHALL check, with UPDOWN_CTRL_DWELL_EN: lo=2, hi=4, sweeps=2 -> 2,3,4,4,3,2,2,3,4,4,3,2, then done.
